// File: rtl/myo_spi_pkg.sv
// Shared constants and types for the myocontrol SPI responder.
package myo_spi_pkg;

    localparam int unsigned WORD_W          = 16;
    localparam int unsigned MAX_FRAME_WORDS = 15;
    localparam logic [15:0] DEFAULT_SYNC_WORD = 16'h8000;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        END
    } state_e;

endpackage

// File: rtl/myo_spi_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin plus a previous-sample
// register that yields single-cycle rise and fall strobes.
module myo_spi_sync (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Reset to 0 so a select held low across reset produces no edge at all.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/myo_spi_slave.sv
// SPI mode-0 responder for the myocontrol link: receives fixed-length 16-bit
// word frames and returns a status frame snapshotted at frame start.
module myo_spi_slave
    import myo_spi_pkg::*;
#(
    parameter int unsigned FRAME_WORDS = 12,
    parameter logic [15:0] SYNC_WORD   = DEFAULT_SYNC_WORD
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              sck,
    input  logic                              mosi,
    input  logic                              ss_n,
    output logic                              miso,
    output logic                              miso_oe,
    input  logic [WORD_W*(FRAME_WORDS-1)-1:0] tx_frame,
    output logic [WORD_W-1:0]                 rx_word,
    output logic [3:0]                        rx_index,
    output logic                              rx_valid,
    output logic                              frame_done,
    output logic                              frame_error
);

    localparam logic [4:0] FW_CNT  = 5'(FRAME_WORDS);
    localparam logic [4:0] CNT_SAT = 5'(MAX_FRAME_WORDS + 1);

    logic sck_level, sck_rise, sck_fall;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;
    logic ss_level, ss_rise, ss_fall;

    myo_spi_sync u_sync_sck (
        .clock (clock),
        .reset (reset),
        .din   (sck),
        .level (sck_level),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    myo_spi_sync u_sync_mosi (
        .clock (clock),
        .reset (reset),
        .din   (mosi),
        .level (mosi_level),
        .rise  (mosi_rise_unused),
        .fall  (mosi_fall_unused)
    );

    myo_spi_sync u_sync_ss (
        .clock (clock),
        .reset (reset),
        .din   (ss_n),
        .level (ss_level),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    state_e                            state_q, state_d;
    logic [WORD_W*(FRAME_WORDS-1)-1:0] shadow_q, shadow_d;
    logic [WORD_W-1:0]                 tx_q, tx_d;
    logic [WORD_W-1:0]                 rx_q, rx_d;
    logic [3:0]                        bit_cnt_q, bit_cnt_d;
    logic [4:0]                        word_cnt_q, word_cnt_d;
    logic                              load_pending_q, load_pending_d;
    logic                              wait_deselect_q, wait_deselect_d;
    logic                              miso_q, miso_d;
    logic                              miso_oe_q, miso_oe_d;
    logic [WORD_W-1:0]                 rx_word_q, rx_word_d;
    logic [3:0]                        rx_index_q, rx_index_d;
    logic                              rx_valid_q, rx_valid_d;
    logic                              frame_done_q, frame_done_d;
    logic                              frame_error_q, frame_error_d;

    logic [4:0]        next_idx;
    logic [WORD_W-1:0] next_tx;

    // Word to send after the current one; zero once past the end of the frame.
    always_comb begin
        next_idx = word_cnt_q + 5'd1;
        next_tx  = '0;
        for (int unsigned i = 1; i < FRAME_WORDS; i++) begin
            if (5'(i) == next_idx) begin
                next_tx = shadow_q[i*WORD_W - WORD_W +: WORD_W];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        shadow_d        = shadow_q;
        tx_d            = tx_q;
        rx_d            = rx_q;
        bit_cnt_d       = bit_cnt_q;
        word_cnt_d      = word_cnt_q;
        load_pending_d  = load_pending_q;
        wait_deselect_d = wait_deselect_q;
        miso_d          = miso_q;
        miso_oe_d       = miso_oe_q;
        rx_word_d       = rx_word_q;
        rx_index_d      = rx_index_q;
        rx_valid_d      = 1'b0;
        frame_done_d    = 1'b0;
        frame_error_d   = 1'b0;

        if (ss_level) begin
            wait_deselect_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                miso_oe_d = 1'b0;
                if (ss_fall && !wait_deselect_q) begin
                    shadow_d       = tx_frame;
                    tx_d           = SYNC_WORD;
                    bit_cnt_d      = '0;
                    word_cnt_d     = '0;
                    load_pending_d = 1'b0;
                    miso_d         = SYNC_WORD[WORD_W-1];
                    miso_oe_d      = 1'b1;
                    state_d        = SHIFT;
                end
            end

            SHIFT: begin
                // Deselect takes priority over a coincident sck edge.
                if (ss_rise) begin
                    state_d = END;
                end else if (sck_rise) begin
                    rx_d      = {rx_q[WORD_W-2:0], mosi_level};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd15) begin
                        if (word_cnt_q < FW_CNT) begin
                            rx_word_d  = {rx_q[WORD_W-2:0], mosi_level};
                            rx_index_d = word_cnt_q[3:0];
                            rx_valid_d = 1'b1;
                        end
                        if (word_cnt_q != CNT_SAT) begin
                            word_cnt_d = word_cnt_q + 5'd1;
                        end
                        tx_d           = next_tx;
                        load_pending_d = 1'b1;
                    end
                end else if (sck_fall) begin
                    // After a word boundary tx already holds the new word: present its MSB unshifted.
                    if (load_pending_q) begin
                        miso_d         = tx_q[WORD_W-1];
                        load_pending_d = 1'b0;
                    end else begin
                        tx_d   = {tx_q[WORD_W-2:0], 1'b0};
                        miso_d = tx_q[WORD_W-2];
                    end
                end
            end

            END: begin
                if (word_cnt_q == FW_CNT && bit_cnt_q == 4'd0) begin
                    frame_done_d = 1'b1;
                end else begin
                    frame_error_d = 1'b1;
                end
                miso_oe_d = 1'b0;
                miso_d    = 1'b0;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // wait_deselect comes out of reset set so a frame cut by reset is ignored to its end.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            shadow_q        <= '0;
            tx_q            <= '0;
            rx_q            <= '0;
            bit_cnt_q       <= '0;
            word_cnt_q      <= '0;
            load_pending_q  <= 1'b0;
            wait_deselect_q <= 1'b1;
            miso_q          <= 1'b0;
            miso_oe_q       <= 1'b0;
            rx_word_q       <= '0;
            rx_index_q      <= '0;
            rx_valid_q      <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_error_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            shadow_q        <= shadow_d;
            tx_q            <= tx_d;
            rx_q            <= rx_d;
            bit_cnt_q       <= bit_cnt_d;
            word_cnt_q      <= word_cnt_d;
            load_pending_q  <= load_pending_d;
            wait_deselect_q <= wait_deselect_d;
            miso_q          <= miso_d;
            miso_oe_q       <= miso_oe_d;
            rx_word_q       <= rx_word_d;
            rx_index_q      <= rx_index_d;
            rx_valid_q      <= rx_valid_d;
            frame_done_q    <= frame_done_d;
            frame_error_q   <= frame_error_d;
        end
    end

    assign miso        = miso_q;
    assign miso_oe     = miso_oe_q;
    assign rx_word     = rx_word_q;
    assign rx_index    = rx_index_q;
    assign rx_valid    = rx_valid_q;
    assign frame_done  = frame_done_q;
    assign frame_error = frame_error_q;

endmodule

// File: tb/tb_myo_spi_slave.sv
// Directed bench for myo_spi_slave: a behavioural SPI master with sck = clock/8.
module tb_myo_spi_slave;

    localparam int unsigned FW = 12;

    logic               clock;
    logic               reset;
    logic               sck;
    logic               mosi;
    logic               ss_n;
    logic               miso;
    logic               miso_oe;
    logic [16*(FW-1)-1:0] tx_frame;
    logic [15:0]        rx_word;
    logic [3:0]         rx_index;
    logic               rx_valid;
    logic               frame_done;
    logic               frame_error;

    myo_spi_slave #(
        .FRAME_WORDS (FW),
        .SYNC_WORD   (16'h8000)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sck         (sck),
        .mosi        (mosi),
        .ss_n        (ss_n),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .tx_frame    (tx_frame),
        .rx_word     (rx_word),
        .rx_index    (rx_index),
        .rx_valid    (rx_valid),
        .frame_done  (frame_done),
        .frame_error (frame_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_words [16];
    logic [15:0] r_words [16];
    logic [15:0] got_word [$];
    logic [3:0]  got_idx  [$];
    int          n_done;
    int          n_err;
    bit          oe_seen;

    always @(negedge clock) begin
        if (rx_valid === 1'b1) begin
            got_word.push_back(rx_word);
            got_idx.push_back(rx_index);
        end
        if (frame_done === 1'b1) n_done++;
        if (frame_error === 1'b1) n_err++;
        if (miso_oe === 1'b1) oe_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        got_word.delete();
        got_idx.delete();
        n_done  = 0;
        n_err   = 0;
        oe_seen = 1'b0;
    endtask

    // Sends nbits bits from m_words (MSB first), capturing miso into r_words, then deselects.
    task automatic spi_frame(input int nbits);
        int w;
        int b;
        for (int k = 0; k < 16; k++) r_words[k] = '0;
        ss_n = 1'b0;
        repeat (2) @(negedge clock);
        check("oe_lat_2", {31'd0, miso_oe}, 32'd0);
        @(negedge clock);
        check("oe_lat_3", {31'd0, miso_oe}, 32'd1);
        repeat (5) @(negedge clock);
        for (int n = 0; n < nbits; n++) begin
            w = n / 16;
            b = 15 - (n % 16);
            mosi = m_words[w][b];
            repeat (4) @(negedge clock);
            r_words[w][b] = miso;
            sck = 1'b1;
            repeat (4) @(negedge clock);
            sck = 1'b0;
        end
        repeat (4) @(negedge clock);
        ss_n = 1'b1;
    endtask

    task automatic end_checks(input string tag, input bit exp_done);
        repeat (3) @(negedge clock);
        check({tag, "_oe_hold"}, {31'd0, miso_oe}, 32'd1);
        @(negedge clock);
        check({tag, "_oe_off"}, {31'd0, miso_oe}, 32'd0);
        check({tag, "_done"}, {31'd0, frame_done}, {31'd0, exp_done});
        check({tag, "_err"}, {31'd0, frame_error}, {31'd0, !exp_done});
        repeat (8) @(negedge clock);
    endtask

    task automatic check_rx(input string tag, input int n);
        check({tag, "_nrx"}, got_word.size(), n);
        for (int k = 0; k < n && k < got_word.size(); k++) begin
            check($sformatf("%s_rxw%0d", tag, k), {16'd0, got_word[k]}, {16'd0, m_words[k]});
            check($sformatf("%s_rxi%0d", tag, k), {28'd0, got_idx[k]}, k);
        end
    endtask

    initial begin
        reset = 1'b1;
        sck   = 1'b0;
        mosi  = 1'b0;
        ss_n  = 1'b1;
        for (int k = 1; k < FW; k++) tx_frame[16*k-16 +: 16] = 16'h1100 + 16'(k);
        for (int k = 0; k < 16; k++) m_words[k] = 16'(k + 1);
        clear_mon();
        repeat (5) @(negedge clock);
        check("rst_outs", {8'd0, miso, miso_oe, rx_valid, frame_done, frame_error, rx_index, rx_word},
              32'd0);
        reset = 1'b0;
        repeat (6) @(negedge clock);

        // Deselected noise
        clear_mon();
        for (int p = 0; p < 20; p++) begin
            mosi = p[0];
            repeat (4) @(negedge clock);
            sck = 1'b1;
            repeat (4) @(negedge clock);
            sck = 1'b0;
        end
        repeat (8) @(negedge clock);
        check("noise_nrx", got_word.size(), 0);
        check("noise_strobes", n_done + n_err, 0);
        check("noise_oe", {31'd0, oe_seen}, 32'd0);

        // Nominal frame
        clear_mon();
        spi_frame(FW * 16);
        end_checks("nom", 1'b1);
        check_rx("nom", FW);
        check("nom_miso0", {16'd0, r_words[0]}, 32'h8000);
        for (int k = 1; k < FW; k++)
            check($sformatf("nom_miso%0d", k), {16'd0, r_words[k]}, 32'h1100 + k);
        check("nom_ndone", n_done, 1);
        check("nom_nerr", n_err, 0);

        // Abort after 3 words plus 7 bits
        clear_mon();
        spi_frame(3 * 16 + 7);
        end_checks("abort", 1'b0);
        check_rx("abort", 3);
        check("abort_ndone", n_done, 0);
        check("abort_nerr", n_err, 1);

        // Overrun: 14 words
        clear_mon();
        spi_frame(14 * 16);
        end_checks("ovr", 1'b0);
        check_rx("ovr", FW);
        check("ovr_miso11", {16'd0, r_words[11]}, 32'h110B);
        check("ovr_miso12", {16'd0, r_words[12]}, 32'h0000);
        check("ovr_miso13", {16'd0, r_words[13]}, 32'h0000);
        check("ovr_ndone", n_done, 0);

        // Shadow copy: change word 1 during word 0
        clear_mon();
        fork
            spi_frame(FW * 16);
            begin
                repeat (40) @(negedge clock);
                tx_frame[15:0] = 16'hBEEF;
            end
        join
        end_checks("shd", 1'b1);
        check("shd_miso1_old", {16'd0, r_words[1]}, 32'h1101);
        clear_mon();
        spi_frame(FW * 16);
        end_checks("shd2", 1'b1);
        check("shd_miso1_new", {16'd0, r_words[1]}, 32'hBEEF);
        check("shd_miso2", {16'd0, r_words[2]}, 32'h1102);
        tx_frame[15:0] = 16'h1101;

        // Reset pulse during word 5 with ss_n held low
        clear_mon();
        fork
            spi_frame(FW * 16);
            begin
                repeat (8 + 5 * 128 + 60) @(negedge clock);
                reset = 1'b1;
                @(negedge clock);
                check("rstmid_outs",
                      {8'd0, miso, miso_oe, rx_valid, frame_done, frame_error, rx_index, rx_word}, 32'd0);
                reset = 1'b0;
                repeat (40) @(negedge clock);
                check("rstmid_oe_low", {31'd0, miso_oe}, 32'd0);
            end
        join
        repeat (12) @(negedge clock);
        check("rstmid_nrx", got_word.size(), 5);
        check("rstmid_ndone", n_done, 0);
        check("rstmid_nerr", n_err, 0);
        check("rstmid_oe_end", {31'd0, miso_oe}, 32'd0);

        // Recovery frame
        clear_mon();
        spi_frame(FW * 16);
        end_checks("rec", 1'b1);
        check_rx("rec", FW);
        check("rec_miso0", {16'd0, r_words[0]}, 32'h8000);
        check("rec_miso11", {16'd0, r_words[11]}, 32'h110B);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
